fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of decode; decode slices instr[31:7] for the immediate extender.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty   = (count == {CW{1'b0}});
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? fetch_entry_t'(64'd0) : mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr <= {PW{1'b0}};
      wr_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, credit-limited memory requests, response
// buffering toward decode, and redirect handling with in-flight response discard.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   CREDITS  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [31:0]   pc_q;
  logic [31:0]   rsp_pc_q;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_cnt_next;
  logic [CW-1:0] inflight_after;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_empty;
  logic          fifo_full;
  logic          req_fire;
  logic          rsp_push;
  logic          id_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  fetch_state_e  state;
  fetch_state_e  state_next;

  assign target_pc        = {redirect_pc_i[31:2], 2'b00};
  assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid_o = !redirect_i && !fifo_full && (credit_used < CREDITS);
  assign imem_addr_o      = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_push         = imem_rsp_valid_i && !redirect_i && (drop_cnt == CNT_ZERO);
  // responses returning in the redirect cycle are already accounted for
  assign inflight_after   = outstanding - CW'(imem_rsp_valid_i);
  assign push_entry       = {rsp_pc_q, imem_rsp_data_i};

  assign id_valid_o    = !fifo_empty;
  assign id_pop        = id_valid_o && id_ready_i && !redirect_i;
  assign id_instr_o    = head.instr;
  assign id_pc_o       = head.pc;
  assign id_pc_plus4_o = head.pc + 32'd4;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (push_entry),
    .pop   (id_pop),
    .flush (redirect_i),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state for credits, discard counter and drain FSM.
  always_comb begin
    outstanding_next = outstanding;
    drop_cnt_next    = drop_cnt;
    state_next       = state;
    if (redirect_i) begin
      outstanding_next = inflight_after;
      drop_cnt_next    = inflight_after;
      state_next       = (inflight_after != CNT_ZERO) ? DRAIN : RUN;
    end else begin
      outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (imem_rsp_valid_i && (drop_cnt != CNT_ZERO)) begin
        drop_cnt_next = drop_cnt - CNT_ONE;
      end else begin
        drop_cnt_next = drop_cnt;
      end
      case (state)
        RUN:     state_next = RUN;
        DRAIN:   state_next = (drop_cnt_next == CNT_ZERO) ? RUN : DRAIN;
        default: state_next = RUN;
      endcase
    end
  end

  // Fetch and response PC registers plus control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outstanding <= CNT_ZERO;
      drop_cnt    <= CNT_ZERO;
      state       <= RUN;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      state       <= state_next;
      if (redirect_i) begin
        pc_q     <= target_pc;
        rsp_pc_q <= target_pc;
      end else begin
        if (req_fire) pc_q     <= pc_q + 32'd4;
        if (rsp_push) rsp_pc_q <= rsp_pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle in-order memory that can be held.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;

  int          n_assert;
  int          n_fail;
  int          accepted;
  int          consumed;
  int          live;
  int          k;
  logic        mem_hold;
  logic [31:0] exp_pc;
  logic [31:0] pend[$];

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_pc_plus4_o    (id_pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: record handshakes, then play the memory for the next cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid_o && imem_req_ready_i && !rst;
    a   = imem_addr_o;
    if (acc) accepted++;
    if (id_valid_o && id_ready_i && !redirect_i && !rst) consumed++;
    @(posedge clk);
    #1;
    if (acc) pend.push_back(a);
    if (!mem_hold && pend.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = word_of(pend.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'd0;
    end
    #1;
  endtask

  // Consume n instructions, expecting consecutive PCs starting at exp_pc.
  task automatic collect(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n * 12 && seen < n; i++) begin
      if (id_valid_o && id_ready_i) begin
        check32({tag, "_pc"}, id_pc_o, exp_pc);
        check32({tag, "_pc4"}, id_pc_plus4_o, exp_pc + 32'd4);
        check32({tag, "_instr"}, id_instr_o, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
      tick();
    end
    check32({tag, "_count"}, 32'(seen), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0; n_fail = 0; accepted = 0; consumed = 0; live = 0; k = 0;
    mem_hold = 1'b0;
    rst = 1'b0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'd0;
    id_ready_i       = 1'b1;
    #1 rst = 1'b1;
    #1;
    check1("rst_req_valid", imem_req_valid_o, 1'b1);
    check32("rst_addr", imem_addr_o, 32'h0000_0000);
    check1("rst_id_valid", id_valid_o, 1'b0);
    check32("rst_id_instr", id_instr_o, 32'd0);
    check32("rst_id_pc", id_pc_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Streaming from reset
    exp_pc = 32'h0000_0000;
    collect(4, "p1");

    // Decode stall: credits cap buffered + in-flight words at the depth
    id_ready_i = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      live = accepted - consumed;
      check1("p2_live_le_depth", (live <= 2), 1'b1);
      tick();
    end
    check1("p2_req_blocked_full", imem_req_valid_o, 1'b0);
    check1("p2_id_valid", id_valid_o, 1'b1);
    check32("p2_head_pc", id_pc_o, exp_pc);
    id_ready_i = 1'b1;
    #1;
    check1("p2_no_req_before_pop", imem_req_valid_o, 1'b0);
    tick();
    check1("p2_req_after_pop", imem_req_valid_o, 1'b1);
    check32("p2_addr_after_pop", imem_addr_o, exp_pc + 32'd8);
    exp_pc = exp_pc + 32'd4;
    collect(4, "p2");

    // Redirect with two responses held in memory
    mem_hold = 1'b1;
    k = 0;
    while (!(pend.size() == 2 && !imem_rsp_valid_i && !id_valid_o) && k < 20) begin
      tick();
      k++;
    end
    check1("p3_setup", (pend.size() == 2 && !id_valid_o), 1'b1);
    check1("p3_credit_block", imem_req_valid_o, 1'b0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    #1;
    check1("p3_no_req_on_redirect", imem_req_valid_o, 1'b0);
    tick();
    redirect_i = 1'b0;
    mem_hold = 1'b0;
    #1;
    check1("p3_t1_id_valid", id_valid_o, 1'b0);
    check32("p3_t1_addr", imem_addr_o, 32'h0000_0100);
    check1("p3_t1_drain_block", imem_req_valid_o, 1'b0);
    exp_pc = 32'h0000_0100;
    collect(3, "p3");

    // Misaligned redirect target is word-aligned
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0203;
    #1;
    check1("p4_no_req_on_redirect", imem_req_valid_o, 1'b0);
    tick();
    redirect_i = 1'b0;
    #1;
    check32("p4_t1_addr", imem_addr_o, 32'h0000_0200);
    check1("p4_t1_id_valid", id_valid_o, 1'b0);
    exp_pc = 32'h0000_0200;
    collect(2, "p4");

    // Redirect coinciding with a response and a decode pop
    k = 0;
    while (!(id_valid_o && imem_rsp_valid_i) && k < 20) begin
      tick();
      k++;
    end
    check1("p5_setup", (id_valid_o && imem_rsp_valid_i), 1'b1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    #1;
    tick();
    redirect_i = 1'b0;
    #1;
    check1("p5_t1_id_valid", id_valid_o, 1'b0);
    check32("p5_t1_id_pc_empty", id_pc_o, 32'd0);
    check1("p5_t1_req_free", imem_req_valid_o, 1'b1);
    exp_pc = 32'h0000_0300;
    collect(2, "p5");

    // Address wrap at the top of the space, then reset mid-stream
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect_i = 1'b0;
    #1;
    exp_pc = 32'hFFFF_FFFC;
    collect(2, "p6");
    rst = 1'b1;
    #1;
    check1("p6_rst_id_valid", id_valid_o, 1'b0);
    check32("p6_rst_addr", imem_addr_o, 32'h0000_0000);
    check1("p6_rst_req_valid", imem_req_valid_o, 1'b1);
    pend.delete();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    exp_pc = 32'h0000_0000;
    collect(2, "p7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
